// File: rtl/zeus_io_pkg.sv
// Shared definitions for the I/O responder: FSM state encoding, the INPUT
// opcode value on confirma_entrada and the default debounce length.
package zeus_io_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        LIBERA = 2'd2,
        PARADO = 2'd3
    } estado_t;

    localparam logic [1:0] CONF_ENTRADA_INPUT   = 2'd1;
    localparam int         DEBOUNCE_CICLOS_PADRAO = 250000;

endpackage

// File: rtl/debounce_botao.sv
// Confirm-button conditioning: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module debounce_botao
    import zeus_io_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    output logic pressao
);

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic          sinc_1;
    logic          sinc_2;
    logic          nivel;
    logic [CW-1:0] cont;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sinc_1  <= 1'b0;
            sinc_2  <= 1'b0;
            nivel   <= 1'b0;
            cont    <= '0;
            pressao <= 1'b0;
        end else begin
            sinc_1  <= botao;
            sinc_2  <= sinc_1;
            pressao <= 1'b0;
            // Any cycle that agrees with the accepted level restarts the count.
            if (sinc_2 == nivel) begin
                cont <= '0;
            end else if (cont == CNT_MAX) begin
                nivel   <= sinc_2;
                cont    <= '0;
                pressao <= sinc_2;
            end else begin
                cont <= cont + CW'(1);
            end
        end
    end

endmodule

// File: rtl/controle_entrada_saida.sv
// I/O responder for the control unit: INPUT/delay requests stall until a
// debounced press, prints are latched for the display, HALT parks the core.
// Optional event counters are built when ZEUS_IO_CONTADORES_EN is defined.
module controle_entrada_saida
    import zeus_io_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            confirma_entrada,
    input  logic                  ler_da_entrada,
    input  logic                  print,
    input  logic                  halt,
    input  logic [DATA_WIDTH-1:0] dado_saida,
    input  logic [SW_WIDTH-1:0]   chaves,
    input  logic                  botao,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] dado_entrada,
    output logic [DATA_WIDTH-1:0] display_valor,
    output logic                  display_valido,
    output logic                  aguardando,
    output logic                  parado,
    output logic [1:0]            estado_dbg
`ifdef ZEUS_IO_CONTADORES_EN
    ,
    output logic [15:0]           cont_entradas,
    output logic [15:0]           cont_saidas
`endif
);

    estado_t estado;
    logic    pedido_entrada;
    logic    pressao;
    logic    req_in;
    logic    captura_print;

    debounce_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .botao   (botao),
        .pressao (pressao)
    );

    assign req_in        = (confirma_entrada == CONF_ENTRADA_INPUT) | ler_da_entrada;
    assign captura_print = print & ~stall;
    assign estado_dbg    = estado;

    // Mealy in OCIOSO so the requesting instruction never advances the PC.
    always_comb begin
        stall = 1'b0;
        case (estado)
            OCIOSO:  stall = halt | req_in;
            ESPERA:  stall = 1'b1;
            LIBERA:  stall = 1'b0;
            PARADO:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
        if (!reset_n) stall = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado         <= OCIOSO;
            pedido_entrada <= 1'b0;
            dado_entrada   <= '0;
            display_valor  <= '0;
            display_valido <= 1'b0;
            aguardando     <= 1'b0;
            parado         <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (halt) begin
                        estado <= PARADO;
                        parado <= 1'b1;
                    end else if (req_in) begin
                        estado         <= ESPERA;
                        aguardando     <= 1'b1;
                        pedido_entrada <= (confirma_entrada == CONF_ENTRADA_INPUT);
                    end
                end
                ESPERA: begin
                    if (pressao) begin
                        if (pedido_entrada) dado_entrada <= DATA_WIDTH'(chaves);
                        estado     <= LIBERA;
                        aguardando <= 1'b0;
                    end
                end
                LIBERA:  estado <= OCIOSO;
                PARADO:  estado <= PARADO;
                default: estado <= OCIOSO;
            endcase
            if (captura_print) begin
                display_valor  <= dado_saida;
                display_valido <= 1'b1;
            end
        end
    end

`ifdef ZEUS_IO_CONTADORES_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_entradas <= '0;
            cont_saidas   <= '0;
        end else begin
            if (estado == ESPERA && pressao) cont_entradas <= cont_entradas + 16'd1;
            if (captura_print)               cont_saidas   <= cont_saidas + 16'd1;
        end
    end
`endif

endmodule

// File: doc/controle_entrada_saida.md
Name: controle_entrada_saida

Overview:
- Sequential I/O responder serving the control unit's I/O opcode signals: INPUT (`confirma_entrada`=1), OUTPUT (`print`), delay/wait (`ler_da_entrada`) and HALT (`halt`).
- Synchronises and debounces the user confirm button, samples the switches, and holds the processor through `stall` until the user confirms.
- Latches printed register values for the display driver.
- Sits between the datapath (PC enable, register write-data mux) and the board I/O.

Parameters:
- DATA_WIDTH, 32, width of the register file and datapath words.
- SW_WIDTH, 16, number of user switches; must be <= DATA_WIDTH.
- DEBOUNCE_CICLOS, 250000, consecutive stable synchronised cycles required to accept a button level change; must be >= 1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- confirma_entrada  in  2  from control unit; value 1 = INPUT request; values 0, 2, 3 ignored.
- ler_da_entrada  in  1  from control unit; delay request = wait for a button press, no data captured.
- print  in  1  from control unit; OUTPUT request.
- halt  in  1  from control unit; HALT opcode decoded.
- dado_saida  in  DATA_WIDTH  register value to print.
- chaves  in  SW_WIDTH  raw user switches; treated as quasi-static.
- botao  in  1  raw confirm button, active-high, asynchronous.
- stall  out  1  1 = hold PC and suppress register/memory writes this cycle.
- dado_entrada  out  DATA_WIDTH  captured switch value, zero-extended; feeds the register write mux.
- display_valor  out  DATA_WIDTH  last printed value.
- display_valido  out  1  1 once any print has occurred since reset.
- aguardando  out  1  user-prompt LED; 1 while waiting for a press.
- parado  out  1  processor halted.

Behaviour:
- Reset (asynchronous, active-low): all of the following are zero, and state = OCIOSO:
  - `stall`, `dado_entrada`, `display_valor`, `display_valido`, `aguardando`, `parado`;
  - synchroniser flops, debounce counter, debounced level.
- Button path:
  - 2-flop synchroniser on `botao`.
  - Counter resets whenever the synchronised value equals the debounced level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CICLOS-1 the debounced level flips and the counter clears.
  - `pressao` = one-cycle pulse on a debounced 0->1 transition. Only edges count, so holding the button never satisfies two requests.
- Request decode: `req_in` = (`confirma_entrada`==1) | `ler_da_entrada`.
- States:
  - OCIOSO:
    - `halt`=1 -> PARADO. `halt` has priority over all other requests in the same cycle.
    - Else `req_in` -> ESPERA, with `stall`=1 combinationally in this same cycle.
  - ESPERA:
    - `stall`=1, `aguardando`=1.
    - On `pressao`: register `dado_entrada` <= zero-extended `chaves`, but only if the request was INPUT; a delay request leaves `dado_entrada` unchanged. Then -> LIBERA.
  - LIBERA:
    - `stall`=0 for exactly one cycle, so the INPUT instruction writes `dado_entrada` and the PC advances.
    - -> OCIOSO.
  - PARADO:
    - `stall`=1, `parado`=1; exited only by reset.
- `stall` is Mealy in OCIOSO (asserted the same cycle a request appears) and Moore elsewhere.
- Print:
  - When `print`=1 and `stall`=0, `display_valor` <= `dado_saida` and `display_valido` <= 1 at that edge.
  - A print is never captured while stalled.
- A press that occurs while in OCIOSO or LIBERA is discarded, not queued.
- Asserting reset mid-ESPERA aborts the request; the switch value is not captured.

Optional Feature:
- Macro ZEUS_IO_CONTADORES_EN.
- Defined:
  - Two extra outputs, `cont_entradas` [15:0] and `cont_saidas` [15:0], reset to 0.
  - `cont_entradas` increments on each ESPERA->LIBERA transition (INPUT and delay).
  - `cont_saidas` increments on each captured print.
  - Both wrap 0xFFFF -> 0x0000.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package `zeus_io_pkg`:
  - state encoding OCIOSO/ESPERA/LIBERA/PARADO;
  - constant CONF_ENTRADA_INPUT = 2'd1;
  - default DEBOUNCE_CICLOS.
- One sub-module: `debounce_botao` (synchroniser + counter + rising-edge pulse, parameter DEBOUNCE_CICLOS).

Test Plan (DEBOUNCE_CICLOS=4):
- INPUT with `chaves`=16'hA5C3:
  - `stall`=1 the same cycle as the request; stays 1 while the button is idle.
  - Button held 6 cycles -> `dado_entrada`=32'h0000A5C3; `stall` low exactly 1 cycle; `aguardando` returns to 0.
- Bounce: button toggling every 2 cycles for 20 cycles -> no `pressao`, `stall` stays 1.
  - Then stable high -> release after 4+2 cycles.
- Back-to-back INPUTs with the button held continuously -> the second INPUT stalls until a release and a new press.
  - `dado_entrada` holds the first value until then.
- Print:
  - `print`=1 with `dado_saida`=32'hDEADBEEF, `stall`=0 -> `display_valor`=32'hDEADBEEF, `display_valido`=1 next edge.
  - `print` during PARADO -> `display_valor` unchanged.
- Halt and INPUT asserted in the same cycle -> PARADO; `stall`=`parado`=1 permanently.
  - Presses ignored; `reset_n` low -> all outputs 0.
- Reset asserted mid-ESPERA -> immediate return to OCIOSO outputs, `dado_entrada`=0.
  - With ZEUS_IO_CONTADORES_EN: `cont_entradas`=0.
